// File: rtl/vedic_pkg.sv
// Shared definitions for the time-multiplexed vedic multiplier:
// controller state type, default widths, iteration count and the 2x2 vedic cell.
package vedic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_RANGE_WIDTH = 16;
    localparam int DEFAULT_CHUNK_WIDTH = 8;

    // Number of chunk-pair partial products needed for one full-width product.
    function automatic int iter_count(input int range_width, input int chunk_width);
        int n;
        n = range_width / chunk_width;
        return n * n;
    endfunction

    // 2x2 vedic cell (urdhva-tiryagbhyam): vertical and crosswise products.
    function automatic logic [3:0] vedic_2x2(input logic [1:0] a, input logic [1:0] b);
        logic c_lo;
        logic c_x0;
        logic c_x1;
        logic c_hi;
        logic carry;
        logic [3:0] p;
        c_lo  = a[0] & b[0];
        c_x0  = a[1] & b[0];
        c_x1  = a[0] & b[1];
        c_hi  = a[1] & b[1];
        carry = c_x0 & c_x1;
        p[0]  = c_lo;
        p[1]  = c_x0 ^ c_x1;
        p[2]  = c_hi ^ carry;
        p[3]  = c_hi & carry;
        return p;
    endfunction

endpackage

// File: rtl/vedic_chunk_mult.sv
// Combinational CHUNK_WIDTH x CHUNK_WIDTH unsigned vedic multiplier built by
// summing shifted 2x2 vedic cells over every pair of 2-bit digits.
module vedic_chunk_mult
    import vedic_pkg::*;
#(
    parameter int CHUNK_WIDTH = DEFAULT_CHUNK_WIDTH
) (
    input  logic [CHUNK_WIDTH-1:0]   a,
    input  logic [CHUNK_WIDTH-1:0]   b,
    output logic [2*CHUNK_WIDTH-1:0] p
);

    localparam int D = CHUNK_WIDTH / 2;

    if ((CHUNK_WIDTH % 2) != 0 || CHUNK_WIDTH < 2) begin : g_bad_chunk
        $error("vedic_chunk_mult: CHUNK_WIDTH must be an even number >= 2");
    end

    logic [2*CHUNK_WIDTH-1:0] sum;

    // Accumulate every digit-pair cell at its positional weight.
    always_comb begin
        sum = '0;
        for (int i = 0; i < D; i++) begin
            for (int j = 0; j < D; j++) begin
                sum = sum + ((2*CHUNK_WIDTH)'(vedic_2x2(a[2*i +: 2], b[2*j +: 2])) << (2*(i+j)));
            end
        end
    end

    assign p = sum;

endmodule

// File: rtl/vedic_mult_sched.sv
// Sequential RANGE_WIDTH x RANGE_WIDTH unsigned multiplier that reuses one
// CHUNK_WIDTH x CHUNK_WIDTH vedic multiplier, one chunk pair per cycle.
// Optional macro VEDIC_SCHED_EARLY_ZERO_EN: a zero operand skips the chunk
// iterations and yields product 0 one cycle after accept.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; operands are accepted only in IDLE (in_ready), the product is held with
// out_valid until out_ready is seen, and out_valid never depends on out_ready.
module vedic_mult_sched
    import vedic_pkg::*;
#(
    parameter int RANGE_WIDTH = DEFAULT_RANGE_WIDTH,
    parameter int CHUNK_WIDTH = DEFAULT_CHUNK_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [RANGE_WIDTH-1:0]   op_a,
    input  logic [RANGE_WIDTH-1:0]   op_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*RANGE_WIDTH-1:0] product,
    output logic                     busy
);

    localparam int N     = RANGE_WIDTH / CHUNK_WIDTH;
    localparam int ITER  = iter_count(RANGE_WIDTH, CHUNK_WIDTH);
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int ACC_W = 2 * RANGE_WIDTH;
    localparam int SH_W  = $clog2(ACC_W) + 1;
    localparam logic [CNT_W-1:0] N_C  = CNT_W'(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    if ((RANGE_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_width
        $error("vedic_mult_sched: RANGE_WIDTH must be a multiple of CHUNK_WIDTH");
    end

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [RANGE_WIDTH-1:0]   a_q, a_d;
    logic [RANGE_WIDTH-1:0]   b_q, b_d;
    logic                     out_valid_q, out_valid_d;
    logic [ACC_W-1:0]         product_q, product_d;

    logic [CNT_W-1:0]         idx_i;
    logic [CNT_W-1:0]         idx_j;
    logic [SH_W-1:0]          sh_a;
    logic [SH_W-1:0]          sh_b;
    logic [SH_W-1:0]          sh_p;
    logic [CHUNK_WIDTH-1:0]   a_chunk;
    logic [CHUNK_WIDTH-1:0]   b_chunk;
    logic [2*CHUNK_WIDTH-1:0] pp;
    logic [ACC_W-1:0]         acc_next;

    // Counter selects the chunk pair: i walks the multiplicand fastest.
    always_comb begin
        idx_i    = cnt_q % N_C;
        idx_j    = cnt_q / N_C;
        sh_a     = SH_W'(idx_i) * SH_W'(CHUNK_WIDTH);
        sh_b     = SH_W'(idx_j) * SH_W'(CHUNK_WIDTH);
        sh_p     = sh_a + sh_b;
        a_chunk  = CHUNK_WIDTH'(a_q >> sh_a);
        b_chunk  = CHUNK_WIDTH'(b_q >> sh_b);
        acc_next = acc_q + (ACC_W'(pp) << sh_p);
    end

    vedic_chunk_mult #(
        .CHUNK_WIDTH (CHUNK_WIDTH)
    ) u_chunk_mult (
        .a (a_chunk),
        .b (b_chunk),
        .p (pp)
    );

    // Next-state and datapath control for IDLE -> RUN -> DONE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        a_d         = a_q;
        b_d         = b_q;
        out_valid_d = out_valid_q;
        product_d   = product_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d   = op_a;
                    b_d   = op_b;
                    cnt_d = '0;
                    acc_d = '0;
`ifdef VEDIC_SCHED_EARLY_ZERO_EN
                    if (op_a == '0 || op_b == '0) begin
                        state_d   = ST_DONE;
                        product_d = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
`else
                    state_d = ST_RUN;
`endif
                end
            end
            ST_RUN: begin
                acc_d = acc_next;
                if (cnt_q == LAST) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    product_d   = acc_next;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
`ifdef VEDIC_SCHED_EARLY_ZERO_EN
                // Early-zero entry arrives with out_valid still low.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end
`endif
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_valid_q <= out_valid_d;
            product_q   <= product_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule

// File: tb/tb_vedic_mult_sched.sv
// Self-checking bench for vedic_mult_sched (16x16, chunk 8).
// Honours VEDIC_SCHED_EARLY_ZERO_EN for the expected zero-operand latency.
module tb_vedic_mult_sched;

    localparam int RW  = 16;
    localparam int PW  = 32;
    localparam int LAT = 4;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] op_a;
    logic [RW-1:0] op_b;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] product;
    logic          busy;

    int n_cmp;
    int n_bad;
    bit chk_en;

    // Reference model state: operation in flight, cycles left, exposed result.
    bit            m_busy;
    int            m_remain;
    bit            m_ov;
    logic [PW-1:0] m_prod;
    logic [PW-1:0] exp_q[$];
    int            m_hs;
    int            d_hs;

    vedic_mult_sched dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic int lat_for(input logic [RW-1:0] a, input logic [RW-1:0] b);
`ifdef VEDIC_SCHED_EARLY_ZERO_EN
        if (a == '0 || b == '0) return 1;
`endif
        return LAT;
    endfunction

    task automatic check(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: advance on each rising edge from the inputs seen there.
    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) d_hs++;
        if (reset) begin
            m_busy   = 0;
            m_remain = 0;
            m_ov     = 0;
            m_prod   = '0;
            exp_q.delete();
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy   = 1;
                m_remain = lat_for(op_a, op_b);
                exp_q.push_back(PW'(op_a) * PW'(op_b));
            end
        end else if (m_remain > 0) begin
            m_remain--;
            if (m_remain == 0) begin
                m_ov   = 1;
                m_prod = exp_q.pop_front();
            end
        end else if (m_ov && out_ready) begin
            m_ov   = 0;
            m_busy = 0;
            m_hs++;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", PW'(in_ready), PW'(!m_busy));
            check("busy", PW'(busy), PW'(m_busy));
            check("out_valid", PW'(out_valid), PW'(m_ov));
            check("product", product, m_prod);
        end
    end

    // Driver: one operation, with 'hold' cycles of back-pressure in DONE.
    task automatic do_op(input logic [RW-1:0] a, input logic [RW-1:0] b, input int hold,
                         input logic [PW-1:0] exp, input string nm);
        bit got;
        int lat;
        got = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            check({nm, "_idle_timeout"}, 32'd0, 32'd1);
            return;
        end
        in_valid  = 1'b1;
        op_a      = a;
        op_b      = b;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        lat = -1;
        for (int k = 0; k < 30; k++) begin
            if (out_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            op_a     = RW'($urandom);
            op_b     = RW'($urandom);
        end
        in_valid = 1'b0;
        check({nm, "_latency"}, PW'(lat), PW'(lat_for(a, b)));
        check({nm, "_product"}, product, exp);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            op_a     = RW'($urandom);
            op_b     = RW'($urandom);
            @(negedge clk);
            check({nm, "_hold_valid"}, PW'(out_valid), 32'd1);
            check({nm, "_hold_product"}, product, exp);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({nm, "_valid_drop"}, PW'(out_valid), 32'd0);
        check({nm, "_ready_back"}, PW'(in_ready), 32'd1);
    endtask

    initial begin
        logic [RW-1:0] ra;
        logic [RW-1:0] rb;
        n_cmp = 0; n_bad = 0; chk_en = 0;
        m_busy = 0; m_remain = 0; m_ov = 0; m_prod = '0; m_hs = 0; d_hs = 0;
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        op_a = 16'h1111; op_b = 16'h2222;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        check("reset_out_valid", PW'(out_valid), 32'd0);
        check("reset_product", product, 32'd0);
        check("reset_in_ready", PW'(in_ready), 32'd1);
        check("reset_busy", PW'(busy), 32'd0);
        @(negedge clk);
        check("reset_wins_in_ready", PW'(in_ready), 32'd1);
        reset = 1'b0; in_valid = 1'b0;

        do_op(16'hFFFF, 16'hFFFF, 0, 32'hFFFE0001, "ones");
        do_op(16'h1234, 16'h5678, 0, 32'h06260060, "t1234");
        do_op(16'h1234, 16'h5678, 3, 32'h06260060, "bp1234");

        // Abandon an operation with reset during its second RUN cycle.
        @(negedge clk);
        in_valid = 1'b1; op_a = 16'hABCD; op_b = 16'h0003; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("abort_busy", PW'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_out_valid", PW'(out_valid), 32'd0);
        check("abort_product", product, 32'd0);
        check("abort_in_ready", PW'(in_ready), 32'd1);
        do_op(16'h0002, 16'h0002, 0, 32'h00000004, "after_abort");

        do_op(16'h0000, 16'hABCD, 0, 32'h00000000, "zero_a");
        do_op(16'hABCD, 16'h0000, 2, 32'h00000000, "zero_b");
        do_op(16'h8000, 16'h8000, 1, 32'h40000000, "msb");
        do_op(16'h00FF, 16'hFF00, 0, 32'h00FE0100, "cross");

        for (int n = 0; n < 1500; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                in_valid  = 1'b0;
                out_ready = 1'($urandom_range(0, 1));
            end
            case ($urandom_range(0, 9))
                0:       ra = 16'h0000;
                1:       ra = 16'hFFFF;
                default: ra = RW'($urandom);
            endcase
            case ($urandom_range(0, 9))
                0:       rb = 16'h0000;
                1:       rb = 16'hFFFF;
                default: rb = RW'($urandom);
            endcase
            do_op(ra, rb, $urandom_range(0, 3), PW'(ra) * PW'(rb), "rand");
        end

        repeat (4) @(negedge clk);
        check("result_count", PW'(d_hs), PW'(m_hs));
        check("queue_empty", PW'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
